// File: rtl/counter_read_sequencer.sv
// Tear-free 64-bit counter reader: issues high/low/high system-op reads and
// retries while the high word changes. The result goes out on a valid/ready port.
package counter_read_sequencer_pkg;
  localparam int unsigned DATA_SIZE = 32;

  typedef enum logic [2:0] {
    RDCYCLE    = 3'd0,
    RDCYCLEH   = 3'd1,
    RDTIME     = 3'd2,
    RDTIMEH    = 3'd3,
    RDINSTRET  = 3'd4,
    RDINSTRETH = 3'd5,
    SCALL      = 3'd6,
    SBREAK     = 3'd7
  } t_sysop;
endpackage

module counter_read_sequencer
  import counter_read_sequencer_pkg::*;
#(
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic                 i_aclk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  input  logic [1:0]           i_req_sel,
  output logic                 o_req_ready,
  output t_sysop               o_op,
  output logic                 o_op_valid,
  input  logic [DATA_SIZE-1:0] i_result,
  output logic                 o_rsp_valid,
  output logic [63:0]          o_rsp_data,
  output logic                 o_rsp_err,
  input  logic                 i_rsp_ready
);

  // Keep at least one bit so MAX_RETRIES = 0 still elaborates; the compare never passes then.
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, HI1, LO, HI2, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [DATA_SIZE-1:0] hi_q, hi_d;
  logic [DATA_SIZE-1:0] lo_q, lo_d;
  logic [63:0]          data_q, data_d;
  logic                 err_q, err_d;
  t_sysop               op_hi, op_lo;

  always_comb begin
    case (sel_q)
      2'd1: begin
        op_hi = RDTIMEH;
        op_lo = RDTIME;
      end
      2'd2: begin
        op_hi = RDINSTRETH;
        op_lo = RDINSTRET;
      end
      default: begin
        op_hi = RDCYCLEH;
        op_lo = RDCYCLE;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    retry_d     = retry_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    data_d      = data_q;
    err_d       = err_q;
    o_op        = RDCYCLE;
    o_op_valid  = 1'b0;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          sel_d   = i_req_sel;
          retry_d = '0;
          if (i_req_sel == 2'd3) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = HI1;
          end
        end
      end
      HI1: begin
        o_op       = op_hi;
        o_op_valid = 1'b1;
        hi_d       = i_result;
        state_d    = LO;
      end
      LO: begin
        o_op       = op_lo;
        o_op_valid = 1'b1;
        lo_d       = i_result;
        state_d    = HI2;
      end
      HI2: begin
        o_op       = op_hi;
        o_op_valid = 1'b1;
        if (i_result == hi_q) begin
          data_d  = {hi_q, lo_q};
          err_d   = 1'b0;
          state_d = RESP;
        end else if (retry_q < RETRY_LIMIT) begin
          // The fresh high word becomes the reference, so the retry resumes at LO.
          hi_d    = i_result;
          retry_d = retry_q + RW'(1);
          state_d = LO;
        end else begin
          data_d  = {i_result, 32'h0};
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      retry_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      retry_q <= retry_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign o_rsp_data = data_q;
  assign o_rsp_err  = err_q;

endmodule

// File: doc/counter_read_sequencer.md
# counter_read_sequencer

Initiator-side sequencer that reads a 64-bit performance counter (cycle, time or instret) through the 32-bit system operation port of the execute stage and returns a tear-free 64-bit value. It issues the high/low/high read sequence, retries when the high word changes between reads, and hands the assembled value to its requester over a valid/ready handshake. It sits between the core's counter-read requester (debug/trace or a multi-word CSR path) and the system execute unit, which it drives with `t_sysop` codes and samples combinationally in the same cycle.

## Interface

- `MAX_RETRIES`, default 3: number of re-reads allowed after a high-word mismatch before the block reports an error.
- `i_aclk` input 1: block clock, shared with the system execute unit.
- `i_reset` input 1: reset, synchronous and active-high.
- `i_req_valid` input 1: a counter read is requested.
- `i_req_sel` input 2: counter to read. 0 = cycle, 1 = time, 2 = instret, 3 = reserved.
- `o_req_ready` output 1: the block accepts a request this cycle.
- `o_op` output `t_sysop`: operation presented to the system execute unit.
- `o_op_valid` output 1: `o_op` is an active read this cycle.
- `i_result` input `DATA_SIZE` (32): execute-unit result for `o_op`, valid in the same cycle.
- `o_rsp_valid` output 1: a response is available.
- `o_rsp_data` output 64: the assembled counter value.
- `o_rsp_err` output 1: the read failed (reserved selector or retries exhausted).
- `i_rsp_ready` input 1: the requester accepts the response.

## Operation

- FSM states: IDLE, HI1, LO, HI2, RESP. Reset forces IDLE.
- IDLE:
  - `o_req_ready` = 1.
  - When `i_req_valid` is high, latch `sel` and clear `retry_cnt`.
  - If `sel` = 3, go to RESP with error set and data 0. Otherwise go to HI1.
- HI1:
  - Drive the H op for `sel` (RDCYCLEH, RDTIMEH or RDINSTRETH) with `o_op_valid` = 1.
  - Capture `hi_a <= i_result`, then go to LO.
- LO:
  - Drive the low op for `sel` (RDCYCLE, RDTIME or RDINSTRET) with `o_op_valid` = 1.
  - Capture `lo <= i_result`, then go to HI2.
- HI2:
  - Drive the H op again and compare `i_result` with `hi_a`.
  - Equal: data <= {hi_a, lo}, err <= 0, go to RESP.
  - Not equal and `retry_cnt` < `MAX_RETRIES`: `hi_a <= i_result`, increment `retry_cnt`, go to LO. The next HI1 is skipped, because the new high word is already captured.
  - Not equal and `retry_cnt` = `MAX_RETRIES`: data <= {i_result, 32'h0}, err <= 1, go to RESP. This returns a value the counter has definitely passed through.
- RESP:
  - `o_rsp_valid` = 1.
  - `o_rsp_data` and `o_rsp_err` hold stable until `i_rsp_ready`; on handshake, go to IDLE.
  - `i_rsp_ready` is ignored in every other state.
- Outputs when not reading:
  - `o_op` = RDCYCLE and `o_op_valid` = 0 in IDLE and RESP.
  - `o_op` must never take SCALL or SBREAK.
- `retry_cnt` width is `$clog2(MAX_RETRIES+1)`. With `MAX_RETRIES` = 0, the first mismatch produces an error.

## Timing

- Reset values: `o_req_ready` = 1, `o_rsp_valid` = 0, `o_rsp_data` = 0, `o_rsp_err` = 0, `o_op_valid` = 0, `o_op` = RDCYCLE, state = IDLE.
- Reset mid-sequence or during RESP discards the request and any pending response; no response is produced.
- Request accepted in cycle N (IDLE with valid):
  - HI1 in N+1, LO in N+2, HI2 in N+3.
  - `o_rsp_valid` rises in N+4 with no retries.
  - Each retry adds 2 cycles (LO, HI2).
  - Worst case: `o_rsp_valid` rises in N+4+2·`MAX_RETRIES`.
- Reserved selector: `o_rsp_valid` rises in N+1.
- `o_rsp_valid` and `i_rsp_ready` high in cycle M: IDLE in M+1, so the next request can be accepted no earlier than M+1. There is no back-to-back acceptance in the response cycle.
- `o_op` and `o_op_valid` are decoded from registered state only (glitch-free). `i_result` is sampled at the clock edge that ends the cycle in which `o_op` is driven.

## Test plan

- **Quiet counter:** cycle counter model at 0x0000_0005_1234_0000 with sel = 0 → `o_op` sequence RDCYCLEH, RDCYCLE, RDCYCLEH; `o_rsp_valid` at N+4; data = 0x0000_0005_1234_0002 (the low word captured in LO); err = 0.
- **Wrap between reads:** cycle counter at 0x0000_0000_FFFF_FFFE at HI1 → HI2 sees high word 1; retry issues RDCYCLE, RDCYCLEH; response at N+6 equals {1, low captured in second LO}; err = 0.
- **Retry exhaustion:** `MAX_RETRIES` = 1, bench forces the high word to change on every H read (2, 3, 4) → err = 1, data = 0x0000_0004_0000_0000, `o_rsp_valid` at N+6.
- **Reserved selector and backpressure:** sel = 3 → `o_rsp_valid` at N+1 with data 0, err = 1. Hold `i_rsp_ready` = 0 for 5 cycles → outputs stable and `o_req_ready` = 0; release → IDLE next cycle.
- **Time and instret mapping:** sel = 1 → ops RDTIMEH, RDTIME, RDTIMEH. sel = 2 → ops RDINSTRETH, RDINSTRET, RDINSTRETH. `o_op_valid` high only in those 3 cycles.
- **Reset mid-operation:** assert `i_reset` while in LO → next cycle all outputs equal their reset values; no `o_rsp_valid`; a fresh request then completes normally.
